// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's control, memory and decode-side signals.
// The master side drives the control/memory inputs; the slave is the sequencer.
interface fetch_sequencer_if #(
  parameter int PC_W = 6
);
  logic            start;
  logic            halt_req;
  logic            jump;
  logic [7:0]      jump_off;
  logic            branch_taken;
  logic [7:0]      branch_off;
  logic [15:0]     mem_data;
  logic            instr_ready;
  logic [PC_W-1:0] pc;
  logic [15:0]     instr_out;
  logic            instr_valid;
  logic [1:0]      state;
  logic            fault;
  logic [7:0]      retired;

  modport master (
    output start, halt_req, jump, jump_off, branch_taken, branch_off,
           mem_data, instr_ready,
    input  pc, instr_out, instr_valid, state, fault, retired
  );

  modport slave (
    input  start, halt_req, jump, jump_off, branch_taken, branch_off,
           mem_data, instr_ready,
    output pc, instr_out, instr_valid, state, fault, retired
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches a word at pc, presents it to decode,
// and on the issue handshake advances pc by 1, a jump or a branch offset.
// A next pc beyond the valid memory depth raises a sticky fault and halts.
module fetch_sequencer #(
  parameter int MEM_DEPTH = 32,
  parameter int PC_W      = 6
) (
  input logic           clk,
  input logic           rst,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_ISSUE = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     instr_q;
  logic            valid_q;
  logic            fault_q;
  logic [7:0]      retired_q;

  logic            fire;
  logic [7:0]      step_off;
  logic [7:0]      sum8;
  logic [PC_W-1:0] next_pc;
  logic            next_oob;

  // Issue handshake and the candidate next pc (jump beats branch beats +1).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    step_off = 8'd1;
    if (bus.jump)              step_off = bus.jump_off;
    else if (bus.branch_taken) step_off = bus.branch_off;
    fire     = (state_q == S_ISSUE) && bus.instr_ready;
    sum8     = 8'(pc_q) + step_off;
    next_pc  = PC_W'(sum8);
    next_oob = (32'(next_pc) >= 32'(MEM_DEPTH));
  end

  // Sequencer FSM with all outputs registered; rst dominates every state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (bus.start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          instr_q <= bus.mem_data;
          valid_q <= 1'b1;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (fire) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
            if (retired_q != 8'hFF) retired_q <= retired_q + 8'd1;
            if (next_oob) begin
              fault_q <= 1'b1;
              state_q <= S_HALT;
            end else if (bus.halt_req) begin
              state_q <= S_HALT;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.state       = state_q;
  assign bus.fault       = fault_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: two instances (memory depth 32 and 64) driven by
// identical stimulus, each compared every cycle against a transaction-level
// reference model, plus directed scenario checks.
module tb_fetch_sequencer;

  localparam int PC_W = 6;
  localparam int M_IDLE = 0, M_FETCH = 1, M_ISSUE = 2, M_HALT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0, halt_req = 1'b0, jump = 1'b0, branch_taken = 1'b0;
  logic       instr_ready = 1'b0;
  logic [7:0] jump_off = '0, branch_off = '0;
  logic [15:0] mem [64];

  fetch_sequencer_if #(.PC_W(PC_W)) a_if ();
  fetch_sequencer_if #(.PC_W(PC_W)) b_if ();

  assign a_if.start = start;         assign b_if.start = start;
  assign a_if.halt_req = halt_req;   assign b_if.halt_req = halt_req;
  assign a_if.jump = jump;           assign b_if.jump = jump;
  assign a_if.jump_off = jump_off;   assign b_if.jump_off = jump_off;
  assign a_if.branch_taken = branch_taken;
  assign b_if.branch_taken = branch_taken;
  assign a_if.branch_off = branch_off;
  assign b_if.branch_off = branch_off;
  assign a_if.instr_ready = instr_ready;
  assign b_if.instr_ready = instr_ready;
  assign a_if.mem_data = mem[a_if.pc];
  assign b_if.mem_data = mem[b_if.pc];

  fetch_sequencer #(.MEM_DEPTH(32), .PC_W(PC_W)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  fetch_sequencer #(.MEM_DEPTH(64), .PC_W(PC_W)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one record per instance, advanced once per clock edge
  // from the architectural rules (mode numbers are the visible state code).
  typedef struct {
    int          mode;
    int          pc;
    logic [15:0] iout;
    bit          valid;
    bit          fault;
    int          ret;
  } model_t;

  model_t m [2];
  int     depth [2] = '{32, 64};

  function automatic void model_step(input int k);
    int off, npc;
    if (rst) begin
      m[k] = '{mode: M_IDLE, pc: 0, iout: 16'h0, valid: 0, fault: 0, ret: 0};
      return;
    end
    case (m[k].mode)
      M_IDLE:  if (start) m[k].mode = M_FETCH;
      M_FETCH: begin
        m[k].iout  = mem[m[k].pc];
        m[k].valid = 1;
        m[k].mode  = M_ISSUE;
      end
      M_ISSUE: if (instr_ready) begin
        off = jump ? int'(jump_off) : (branch_taken ? int'(branch_off) : 1);
        npc = ((m[k].pc + off) % 256) % (1 << PC_W);
        m[k].pc    = npc;
        m[k].valid = 0;
        if (m[k].ret < 255) m[k].ret++;
        if (npc >= depth[k]) begin
          m[k].fault = 1;
          m[k].mode  = M_HALT;
        end else if (halt_req) begin
          m[k].mode = M_HALT;
        end else begin
          m[k].mode = M_FETCH;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic cmp_one(input string who, input int k, input logic [PC_W-1:0] pc,
                         input logic [1:0] st, input logic v, input logic [15:0] io,
                         input logic f, input logic [7:0] r);
    check({who, ".pc"},          32'(pc), 32'(m[k].pc));
    check({who, ".state"},       32'(st), 32'(m[k].mode));
    check({who, ".instr_valid"}, 32'(v),  32'(m[k].valid));
    check({who, ".instr_out"},   32'(io), 32'(m[k].iout));
    check({who, ".fault"},       32'(f),  32'(m[k].fault));
    check({who, ".retired"},     32'(r),  32'(m[k].ret));
  endtask

  // One clock: model advances on the edge, outputs compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    cmp_one("a", 0, a_if.pc, a_if.state, a_if.instr_valid, a_if.instr_out,
            a_if.fault, a_if.retired);
    cmp_one("b", 1, b_if.pc, b_if.state, b_if.instr_valid, b_if.instr_out,
            b_if.fault, b_if.retired);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance with ready low until instance a presents an instruction (bounded).
  task automatic wait_issue();
    int n = 0;
    instr_ready = 1'b0;
    while (a_if.state != 2'b10 && n < 8) begin
      tick();
      n++;
    end
    check("reach_issue", 32'(a_if.state), 32'd2);
  endtask

  task automatic fire(input logic j, input logic [7:0] jo, input logic b,
                      input logic [7:0] bo, input logic h);
    jump = j; jump_off = jo; branch_taken = b; branch_off = bo; halt_req = h;
    instr_ready = 1'b1;
    tick();
    jump = 0; jump_off = '0; branch_taken = 0; branch_off = '0; halt_req = 0;
    instr_ready = 1'b0;
  endtask

  logic [15:0] held;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    @(negedge clk);
    do_reset();
    tick();
    check("rst.state", 32'(a_if.state), 32'd0);
    check("rst.pc", 32'(a_if.pc), 32'd0);
    check("rst.valid", 32'(a_if.instr_valid), 32'd0);
    check("rst.retired", 32'(a_if.retired), 32'd0);

    // Sequential fetch with backpressure at pc=2, then halt at pc=4.
    pulse_start();
    check("seq.fetch_state", 32'(a_if.state), 32'd1);
    wait_issue();
    check("seq.io0", 32'(a_if.instr_out), 32'(mem[0]));
    fire(0, 0, 0, 0, 0);
    check("seq.pc1", 32'(a_if.pc), 32'd1);
    wait_issue();
    check("seq.io1", 32'(a_if.instr_out), 32'(mem[1]));
    fire(0, 0, 0, 0, 0);
    wait_issue();
    held = a_if.instr_out;
    check("bp.io2", 32'(held), 32'(mem[2]));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.pc", 32'(a_if.pc), 32'd2);
      check("bp.valid", 32'(a_if.instr_valid), 32'd1);
      check("bp.io_hold", 32'(a_if.instr_out), 32'(held));
    end
    fire(0, 0, 0, 0, 0);
    check("bp.pc3", 32'(a_if.pc), 32'd3);
    wait_issue();
    check("seq.io3", 32'(a_if.instr_out), 32'(mem[3]));
    fire(0, 0, 0, 0, 0);
    check("seq.retired4", 32'(a_if.retired), 32'd4);
    wait_issue();
    fire(0, 0, 0, 0, 1);
    check("halt.pc5", 32'(a_if.pc), 32'd5);
    check("halt.state", 32'(a_if.state), 32'd3);
    check("halt.retired5", 32'(a_if.retired), 32'd5);
    pulse_start();
    tick();
    check("halt.sticky_state", 32'(a_if.state), 32'd3);
    check("halt.sticky_pc", 32'(a_if.pc), 32'd5);

    // Priority, branch and fault path.
    do_reset();
    pulse_start();
    wait_issue();
    fire(1, 8'd13, 0, 0, 0);
    wait_issue();
    fire(0, 0, 1, 8'd6, 0);
    check("br.pc19", 32'(a_if.pc), 32'd19);
    wait_issue();
    fire(1, 8'd3, 1, 8'd6, 0);
    check("prio.pc22", 32'(a_if.pc), 32'd22);
    wait_issue();
    fire(1, 8'd8, 0, 0, 0);
    wait_issue();
    check("fault.pc30", 32'(a_if.pc), 32'd30);
    fire(1, 8'd5, 0, 0, 0);
    check("fault.pc35", 32'(a_if.pc), 32'd35);
    check("fault.flag", 32'(a_if.fault), 32'd1);
    check("fault.state", 32'(a_if.state), 32'd3);
    check("fault.b_clear", 32'(b_if.fault), 32'd0);
    pulse_start();
    tick();
    check("fault.frozen_pc", 32'(a_if.pc), 32'd35);
    check("fault.frozen_state", 32'(a_if.state), 32'd3);

    // Reset in the middle of an issue handshake.
    do_reset();
    pulse_start();
    wait_issue();
    fire(1, 8'd7, 0, 0, 0);
    wait_issue();
    check("midrst.pc7", 32'(a_if.pc), 32'd7);
    instr_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_ready = 1'b0;
    check("midrst.state", 32'(a_if.state), 32'd0);
    check("midrst.pc", 32'(a_if.pc), 32'd0);
    check("midrst.io", 32'(a_if.instr_out), 32'd0);
    check("midrst.valid", 32'(a_if.instr_valid), 32'd0);
    check("midrst.retired", 32'(a_if.retired), 32'd0);

    // Saturation: >300 fires on the depth-64 instance, pc wrapping.
    pulse_start();
    instr_ready = 1'b1;
    for (int i = 0; i < 700; i++) tick();
    instr_ready = 1'b0;
    check("sat.retired", 32'(b_if.retired), 32'd255);
    check("sat.b_fault", 32'(b_if.fault), 32'd0);
    check("sat.a_fault", 32'(a_if.fault), 32'd1);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      start        = ($urandom_range(0, 7) == 0);
      instr_ready  = 1'($urandom);
      jump         = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      jump_off     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      branch_off   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 4));
      halt_req     = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
